// File: rtl/text_pkg.sv
// Shared constants and payload types for the text display datapath.
package text_pkg;

   localparam int unsigned COLS         = 100;
   localparam int unsigned ROWS         = 30;
   localparam int unsigned CHAR_W       = 8;
   localparam int unsigned CHAR_H       = 16;
   localparam int unsigned ADDR_W       = 16;
   localparam int unsigned BLINK_FRAMES = 30;

   // Column index is in_x>>3, screen row is in_y>>4, text row fits ROWS.
   localparam int unsigned COL_W  = 8;
   localparam int unsigned YROW_W = 6;
   localparam int unsigned ROW_W  = 5;

   localparam logic [15:0] DEFAULT_FG = 16'hFFFF;
   localparam logic [15:0] DEFAULT_BG = 16'h0000;

   // RGB565 field positions.
   localparam int unsigned R_MSB = 15;
   localparam int unsigned R_LSB = 11;
   localparam int unsigned G_MSB = 10;
   localparam int unsigned G_LSB = 5;
   localparam int unsigned B_MSB = 4;
   localparam int unsigned B_LSB = 0;

   typedef struct packed {
      logic [R_MSB-R_LSB:0] r;
      logic [G_MSB-G_LSB:0] g;
      logic [B_MSB-B_LSB:0] b;
   } rgb565_t;

endpackage

// File: rtl/text_cell_addr.sv
// Text RAM cell address: wraps screen row by scroll origin, then row*COLS+col.
module text_cell_addr
   import text_pkg::*;
#(
   parameter int unsigned COLS   = text_pkg::COLS,
   parameter int unsigned ROWS   = text_pkg::ROWS,
   parameter int unsigned ADDR_W = text_pkg::ADDR_W
) (
   input  logic [ROW_W-1:0]  row,
   input  logic [ROW_W-1:0]  scroll,
   input  logic [COL_W-1:0]  col,
   output logic [ADDR_W-1:0] addr
);

   localparam int unsigned SUM_W = ROW_W + 1;

   logic [SUM_W-1:0] sum;
   logic [ROW_W-1:0] crow;

   // Both operands are below ROWS, so one conditional subtract wraps the row.
   always_comb begin
      sum  = {1'b0, row} + {1'b0, scroll};
      crow = sum[ROW_W-1:0];
      if (sum >= SUM_W'(ROWS)) begin
         crow = ROW_W'(sum - SUM_W'(ROWS));
      end
   end

   if (COLS == 100) begin : g_x100
      // x100 = x64 + x32 + x4
      assign addr = (ADDR_W'(crow) << 6) + (ADDR_W'(crow) << 5)
                  + (ADDR_W'(crow) << 2) + ADDR_W'(col);
   end else begin : g_mul
      assign addr = ADDR_W'(crow) * ADDR_W'(COLS) + ADDR_W'(col);
   end

endmodule

// File: rtl/text_scanout_reader.sv
// Text-mode scanout: char RAM -> font ROM -> RGB565, 4-cycle pipeline with
// frame-synchronous scroll and a blinking block cursor.
module text_scanout_reader
   import text_pkg::*;
#(
   parameter int unsigned COLS         = text_pkg::COLS,
   parameter int unsigned ROWS         = text_pkg::ROWS,
   parameter int unsigned ADDR_W       = text_pkg::ADDR_W,
   parameter int unsigned BLINK_FRAMES = text_pkg::BLINK_FRAMES
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_de,
   input  logic              in_hsync,
   input  logic              in_vsync,
   input  logic [10:0]       in_x,
   input  logic [9:0]        in_y,
   output logic [ADDR_W-1:0] tram_raddr,
   input  logic [7:0]        tram_rdata,
   output logic [11:0]       font_raddr,
   input  logic [7:0]        font_rdata,
   input  logic [15:0]       fg_color,
   input  logic [15:0]       bg_color,
   input  logic [4:0]        scroll_row,
   input  logic [ADDR_W-1:0] cursor_addr,
   input  logic              cursor_en,
   output logic              LCD_DE,
   output logic              LCD_HSYNC,
   output logic              LCD_VSYNC,
   output logic [4:0]        LCD_R,
   output logic [5:0]        LCD_G,
   output logic [4:0]        LCD_B
);

   localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [COL_W-1:0]   col_raw, col_cl;
   logic [YROW_W-1:0]  row_raw;
   logic [ROW_W-1:0]   row_cl;
   logic [ADDR_W-1:0]  cell_addr;

   logic               vs_prev, frame_start;
   logic [ROW_W-1:0]   scroll_lat;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   logic [2:0] x1, x2;
   logic [3:0] y1;
   logic       rng1, rng2, rng3;
   logic       cur1, cur2, cur3;
   logic       pix3;
   logic [2:0] de_d, hs_d, vs_d;
   rgb565_t    rgb_next;

   // Clamp out-of-screen coordinates so blanking-time addresses stay in range.
   always_comb begin
      col_raw = in_x[10:3];
      row_raw = in_y[9:4];
      col_cl  = (col_raw >= COL_W'(COLS)) ? COL_W'(COLS - 1) : col_raw;
      row_cl  = (row_raw >= YROW_W'(ROWS)) ? ROW_W'(ROWS - 1) : row_raw[ROW_W-1:0];
   end

   text_cell_addr #(
      .COLS   (COLS),
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W)
   ) u_cell_addr (
      .row    (row_cl),
      .scroll (scroll_lat),
      .col    (col_cl),
      .addr   (cell_addr)
   );

   assign frame_start = in_vsync & ~vs_prev;

   // Frame-start bookkeeping: scroll origin latch and cursor blink timer.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vs_prev     <= 1'b0;
         scroll_lat  <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         vs_prev <= in_vsync;
         if (frame_start) begin
            if (scroll_row < ROW_W'(ROWS)) begin
               scroll_lat <= scroll_row;
            end
            if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + BLINK_W'(1);
            end
         end
      end
   end

   // S1..S3: text RAM address, font ROM address, glyph bit select; syncs ride along.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tram_raddr <= '0;
         font_raddr <= '0;
         x1         <= '0;
         y1         <= '0;
         x2         <= '0;
         rng1       <= 1'b0;
         rng2       <= 1'b0;
         rng3       <= 1'b0;
         cur1       <= 1'b0;
         cur2       <= 1'b0;
         cur3       <= 1'b0;
         pix3       <= 1'b0;
         de_d       <= '0;
         hs_d       <= '0;
         vs_d       <= '0;
      end else begin
         tram_raddr <= cell_addr;
         x1         <= in_x[2:0];
         y1         <= in_y[3:0];
         rng1       <= in_de && (col_raw < COL_W'(COLS)) && (row_raw < YROW_W'(ROWS));
         cur1       <= cursor_en && (cell_addr == cursor_addr);

         font_raddr <= {tram_rdata, y1};
         x2         <= x1;
         rng2       <= rng1;
         cur2       <= cur1;

         pix3       <= font_rdata[~x2];
         rng3       <= rng2;
         cur3       <= cur2;

         de_d       <= {de_d[1:0], in_de};
         hs_d       <= {hs_d[1:0], in_hsync};
         vs_d       <= {vs_d[1:0], in_vsync};
      end
   end

   // S4 colour select: blank outside DE, background outside the text area.
   always_comb begin
      rgb_next = '0;
      if (de_d[2]) begin
         if (!rng3) begin
            rgb_next = rgb565_t'(bg_color);
         end else if (pix3 ^ (cur3 & blink_phase)) begin
            rgb_next = rgb565_t'(fg_color);
         end else begin
            rgb_next = rgb565_t'(bg_color);
         end
      end
   end

   // S4 output register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         LCD_DE    <= 1'b0;
         LCD_HSYNC <= 1'b0;
         LCD_VSYNC <= 1'b0;
         LCD_R     <= '0;
         LCD_G     <= '0;
         LCD_B     <= '0;
      end else begin
         LCD_DE    <= de_d[2];
         LCD_HSYNC <= hs_d[2];
         LCD_VSYNC <= vs_d[2];
         LCD_R     <= rgb_next.r;
         LCD_G     <= rgb_next.g;
         LCD_B     <= rgb_next.b;
      end
   end

endmodule

// File: tb/tb_text_scanout_reader.sv
// Directed bench for text_scanout_reader with behavioural text RAM and font ROM.
module tb_text_scanout_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_de, in_hsync, in_vsync;
   logic [10:0] in_x;
   logic [9:0]  in_y;
   logic [15:0] tram_raddr;
   logic [7:0]  tram_rdata;
   logic [11:0] font_raddr;
   logic [7:0]  font_rdata;
   logic [15:0] fg_color, bg_color;
   logic [4:0]  scroll_row;
   logic [15:0] cursor_addr;
   logic        cursor_en;
   logic        LCD_DE, LCD_HSYNC, LCD_VSYNC;
   logic [4:0]  LCD_R;
   logic [5:0]  LCD_G;
   logic [4:0]  LCD_B;

   logic [7:0] tram_mem [65536];
   logic [7:0] font_mem [4096];

   int checks = 0;
   int errors = 0;

   // Expected-output delay line (4 deep) and one-deep expected address.
   logic        pv  [4];
   logic [15:0] prgb[4];
   logic        pde [4];
   logic        phs [4];
   logic        pvs [4];
   logic        pa_v;
   int          pa_e;

   text_scanout_reader #(.BLINK_FRAMES(2)) dut (
      .CLK         (clk),
      .RST         (rst),
      .in_de       (in_de),
      .in_hsync    (in_hsync),
      .in_vsync    (in_vsync),
      .in_x        (in_x),
      .in_y        (in_y),
      .tram_raddr  (tram_raddr),
      .tram_rdata  (tram_rdata),
      .font_raddr  (font_raddr),
      .font_rdata  (font_rdata),
      .fg_color    (fg_color),
      .bg_color    (bg_color),
      .scroll_row  (scroll_row),
      .cursor_addr (cursor_addr),
      .cursor_en   (cursor_en),
      .LCD_DE      (LCD_DE),
      .LCD_HSYNC   (LCD_HSYNC),
      .LCD_VSYNC   (LCD_VSYNC),
      .LCD_R       (LCD_R),
      .LCD_G       (LCD_G),
      .LCD_B       (LCD_B)
   );

   always #5 clk = ~clk;

   // Memory read ports answer within the cycle after the address is presented.
   always @(negedge clk) begin
      tram_rdata <= tram_mem[tram_raddr];
      font_rdata <= font_mem[font_raddr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_pipe();
      for (int i = 0; i < 4; i++) pv[i] = 1'b0;
      pa_v = 1'b0;
   endtask

   // One pixel clock: check what left the pipeline, then drive the next input.
   task automatic cycle(input logic de, input logic hs, input logic vs,
                        input int x, input int y, input logic [15:0] rgb,
                        input int addr = -1);
      @(negedge clk);
      if (pa_v) check("tram_raddr", 32'(tram_raddr), 32'(pa_e));
      pa_v = (addr >= 0);
      pa_e = addr;
      if (pv[3]) begin
         check("rgb",   32'({LCD_R, LCD_G, LCD_B}), 32'(prgb[3]));
         check("de",    32'(LCD_DE),    32'(pde[3]));
         check("hsync", 32'(LCD_HSYNC), 32'(phs[3]));
         check("vsync", 32'(LCD_VSYNC), 32'(pvs[3]));
      end
      for (int i = 3; i > 0; i--) begin
         pv[i] = pv[i-1]; prgb[i] = prgb[i-1];
         pde[i] = pde[i-1]; phs[i] = phs[i-1]; pvs[i] = pvs[i-1];
      end
      pv[0] = 1'b1; prgb[0] = rgb; pde[0] = de; phs[0] = hs; pvs[0] = vs;
      in_de    = de;
      in_hsync = hs;
      in_vsync = vs;
      in_x     = 11'(x);
      in_y     = 10'(y);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 16'h0000);
   endtask

   logic [15:0] blink_exp [6];
   logic [15:0] glyph_exp [8];

   initial begin
      for (int i = 0; i < 65536; i++) tram_mem[i] = 8'h00;
      for (int i = 0; i < 4096; i++)  font_mem[i] = 8'h00;
      tram_mem[0]      = 8'h41;
      font_mem[12'h410] = 8'h81;

      blink_exp = '{16'h001F, 16'h001F, 16'hF800, 16'hF800, 16'h001F, 16'h001F};
      glyph_exp = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                    16'h0000, 16'h0000, 16'h0000, 16'hFFFF};

      rst = 1'b1;
      in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
      in_x = '0; in_y = '0;
      fg_color = 16'hFFFF; bg_color = 16'h0000;
      scroll_row = '0; cursor_addr = '0; cursor_en = 1'b0;
      clear_pipe();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rgb",   32'({LCD_R, LCD_G, LCD_B}), 32'h0);
      check("rst_de",    32'(LCD_DE), 32'h0);
      check("rst_tram",  32'(tram_raddr), 32'h0);
      check("rst_font",  32'(font_raddr), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset in the middle of a driven line
      idle(4);
      repeat (6) cycle(1'b1, 1'b1, 1'b0, 0, 0, 16'hFFFF, 0);
      @(posedge clk);
      #2;
      in_de = 1'b0; in_hsync = 1'b0;
      rst = 1'b1;
      #1;
      check("async_rgb",   32'({LCD_R, LCD_G, LCD_B}), 32'h0);
      check("async_de",    32'(LCD_DE), 32'h0);
      check("async_hsync", 32'(LCD_HSYNC), 32'h0);
      check("async_font",  32'(font_raddr), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_pipe();
      idle(2);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 16'hFFFF, 0);
      cycle(1'b1, 1'b0, 1'b0, 1, 0, 16'h0000, 0);
      idle(4);

      // Cursor blink with 2 frames per phase; frame 0 starts at reset release
      tram_mem[0] = 8'h20;
      fg_color = 16'hF800; bg_color = 16'h001F;
      cursor_en = 1'b1; cursor_addr = 16'd0;
      for (int f = 0; f < 6; f++) begin
         if (f > 0) begin
            cycle(1'b0, 1'b0, 1'b1, 0, 0, 16'h0000);
            idle(1);
         end
         for (int x = 0; x < 8; x++) cycle(1'b1, 1'b0, 1'b0, x, 0, blink_exp[f], 0);
         idle(4);
      end
      cursor_en = 1'b0;

      // Glyph decode, bit7 leftmost
      tram_mem[0] = 8'h41;
      fg_color = 16'hFFFF; bg_color = 16'h0000;
      for (int x = 0; x < 8; x++) cycle(1'b1, 1'b0, 1'b0, x, 0, glyph_exp[x], 0);
      idle(4);

      // Addressing
      cycle(1'b1, 1'b0, 1'b0, 8, 16, 16'h0000, 101);
      cycle(1'b1, 1'b0, 1'b0, 799, 479, 16'h0000, 2999);
      idle(4);

      // Scroll: mid-frame change has no effect until the next vsync rise
      scroll_row = 5'd29;
      cycle(1'b1, 1'b0, 1'b0, 0, 16, 16'h0000, 100);
      idle(2);
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 16'h0000);
      idle(1);
      cycle(1'b1, 1'b0, 1'b0, 0, 16, 16'hFFFF, 0);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 16'h0000, 2900);
      cycle(1'b1, 1'b0, 1'b0, 0, 32, 16'h0000, 100);
      scroll_row = 5'd31;
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 16'h0000);
      idle(1);
      cycle(1'b1, 1'b0, 1'b0, 0, 16, 16'hFFFF, 0);
      scroll_row = 5'd0;
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 16'h0000);
      idle(1);
      cycle(1'b1, 1'b0, 1'b0, 0, 16, 16'h0000, 100);
      idle(4);

      // DE gating, out-of-area background, address clamping, sync delay
      bg_color = 16'h1234;
      cycle(1'b0, 1'b0, 1'b0, 0, 0, 16'h0000, 0);
      cycle(1'b1, 1'b0, 1'b0, 800, 0, 16'h1234, 99);
      cycle(1'b1, 1'b0, 1'b0, 0, 480, 16'h1234, 2900);
      cycle(1'b0, 1'b0, 1'b0, 2047, 1023, 16'h0000, 2999);
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 16'h0000);
      cycle(1'b0, 1'b1, 1'b1, 0, 0, 16'h0000);
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 16'h0000);
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/text_scanout_reader.md
Name: text_scanout_reader

Overview:
- Read-side counterpart of the text-buffer write port (wen/waddr/wdata) that feeds the LCD text display.
- Takes pixel timing (x, y, DE, syncs) from the timing generator and reads character codes from the text RAM read port.
- Looks up glyph rows in the font ROM and emits RGB565 pixels with syncs delayed to match.
- Adds frame-synchronous vertical scroll and a blinking block cursor.

Parameters:
- COLS, 100, character columns per screen
- ROWS, 30, character rows per screen
- CHAR_W, 8, glyph width in pixels; fixed at 8 (one font byte)
- CHAR_H, 16, glyph height in pixels; fixed at 16 (4-bit row index)
- ADDR_W, 16, text RAM address width
- BLINK_FRAMES, 30, frames per cursor blink phase

Ports:
- CLK  in  1  pixel clock, one pixel per cycle
- RST  in  1  asynchronous active-high reset
- in_de  in  1  active-video strobe from timing generator
- in_hsync  in  1  hsync, active high
- in_vsync  in  1  vsync, active high
- in_x  in  11  active pixel column, valid when in_de=1
- in_y  in  10  active pixel line, valid when in_de=1
- tram_raddr  out  ADDR_W  text RAM read address
- tram_rdata  in  8  character code, valid 1 cycle after tram_raddr (synchronous RAM)
- font_raddr  out  12  {char[7:0], glyph_row[3:0]}
- font_rdata  in  8  glyph row, valid 1 cycle after font_raddr; bit7 = leftmost pixel
- fg_color  in  16  foreground RGB565
- bg_color  in  16  background RGB565
- scroll_row  in  5  display row origin, 0..ROWS-1
- cursor_addr  in  ADDR_W  text RAM address of cursor cell
- cursor_en  in  1  cursor enable
- LCD_DE  out  1  delayed in_de
- LCD_HSYNC  out  1  delayed in_hsync
- LCD_VSYNC  out  1  delayed in_vsync
- LCD_R  out  5  red
- LCD_G  out  6  green
- LCD_B  out  5  blue

Behaviour:
- Reset: all outputs 0, tram_raddr=0, font_raddr=0; pipeline valids cleared; blink counter=0, blink phase=0; latched scroll=0.
- Pipeline, 4 registered stages. Pixel presented at cycle t appears on LCD_* at cycle t+4. DE and syncs ride the same delay line.
- S1 (t+1): col=in_x>>3, crow=(in_y>>4)+scroll_lat; if crow>=ROWS then crow-=ROWS. tram_raddr=crow*COLS+col, computed with shifts/adds (x100 = x64+x32+x4). Register x[2:0], y[3:0], in_range=(col<COLS && (in_y>>4)<ROWS && in_de), and is_cursor=(address==cursor_addr).
- S2 (t+2): font_raddr={tram_rdata, y[3:0]}. Forward x[2:0], in_range, is_cursor.
- S3 (t+3): pix=font_rdata[7-x[2:0]].
- S4 (t+4): colour selection:
  - DE low → RGB=0.
  - DE high, !in_range → bg_color.
  - Otherwise, invert=cursor_en&&is_cursor&&blink_phase; colour = (pix^invert) ? fg_color : bg_color.
  - RGB565 split: R=[15:11], G=[10:5], B=[4:0].
- Address path is free-running: tram_raddr and font_raddr update every cycle regardless of DE. Their values while DE=0 are don't-care but must stay in range: clamp col to COLS-1, crow<ROWS.
- Frame start = rising edge of in_vsync, detected with a registered previous value.
  - At frame start: scroll_lat<=scroll_row; values >=ROWS are ignored and the previous value is kept.
  - At frame start, blink counter increments. When it reaches BLINK_FRAMES-1, the next edge wraps it to 0 and toggles blink_phase.
- scroll_row changes mid-frame do not affect the current frame (no tearing).
- Row wrap: scroll_lat=29 with screen row 1 → text row 0.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). After release, output is valid from the 4th cycle onward; the first frame uses scroll=0.
- cursor_addr/cursor_en are sampled per pixel; no latching.

Decomposition:
- Shared package text_pkg:
  - constants COLS, ROWS, CHAR_W, CHAR_H, ADDR_W, default colours;
  - RGB565 field-slice constants.
- One natural sub-module: text_cell_addr. Combinational crow wrap plus row*COLS+col. It is reused by the writer side for cursor/scroll-aware write addressing.

Test Plan:
- Reset: RST=1 mid-line → LCD_R/G/B/DE/HSYNC/VSYNC=0 the same cycle. After release, first driven pixel appears 4 cycles after the first in_de=1.
- Glyph decode:
  - Setup: text RAM[0]=0x41; font ROM {0x41,row0}=0x81; fg=0xFFFF, bg=0x0000, scroll=0.
  - Stimulus: x=0..7, y=0.
  - Expected: pixels x=0 and x=7 are white, x=1..6 black; each at input cycle +4.
- Addressing: y=16, x=8 → tram_raddr=101. y=479, x=799 → tram_raddr=2999.
- Scroll wrap:
  - scroll_row=29 set mid-frame → no change until the next vsync rise.
  - After the next vsync rise, y=16 → tram_raddr=0.
  - scroll_row=31 → ignored.
- Cursor blink:
  - Setup: BLINK_FRAMES=2, cursor_en=1, cursor_addr=0, glyph row byte=0x00, fg=0xF800, bg=0x001F.
  - Frames 0-1: pixels (0..7, 0) = 0x001F.
  - Frames 2-3: pixels (0..7, 0) = 0xF800.
  - Frames 4-5: pixels (0..7, 0) = 0x001F.
- DE gating: in_de=0 with valid x/y → RGB=0 four cycles later. Syncs pass through with exactly 4-cycle delay.
